// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register file with write-through bypass, immediate
// extension, destination select, load-use stall and a registered ID/EX stage.
module id_stage_pipe #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   Ins,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_op,
  output logic [DW-1:0] out_rdata1,
  output logic [DW-1:0] out_rdata2,
  output logic [DW-1:0] out_imm,
  output logic [AW-1:0] out_wadr,
  output logic          out_we,
  output logic [15:0]   hazard_cnt
);

  localparam int NREG = 1 << AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DW-1:0] rf [NREG];

  function automatic logic [DW-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: r[15:0] = imm;
      OP_LUI: begin
        r       = {DW{imm[15]}};
        r[31:0] = {imm, 16'h0000};
      end
      default: begin
        r       = {DW{imm[15]}};
        r[15:0] = imm;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [5:0]    op;
  logic [AW-1:0] rs_a, rt_a, rd_a, dst;
  logic [DW-1:0] rs_val, rt_val, imm_val;
  logic          dec_we, use_rs, use_rt, hazard, adv;

  assign op   = Ins[31:26];
  assign rs_a = AW'(Ins[25:21]);
  assign rt_a = AW'(Ins[20:16]);
  assign rd_a = AW'(Ins[15:11]);

  always_comb begin
    dst = rt_a;
    case (op)
      OP_JAL:   dst = AW'(31);
      OP_RTYPE: dst = rd_a;
      default:  dst = rt_a;
    endcase
  end

  assign dec_we  = !(op inside {OP_J, OP_BEQ, OP_BNE, OP_SW}) && (dst != '0);
  assign use_rt  = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  assign use_rs  = !(op inside {OP_J, OP_JAL});
  assign imm_val = ext_imm(op, Ins[15:0]);

  // Write-through: a same-cycle writeback to the read address wins over the array
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_a != '0) rs_val = (wb_we && wb_adr == rs_a) ? wb_data : rf[rs_a];
    if (rt_a != '0) rt_val = (wb_we && wb_adr == rt_a) ? wb_data : rf[rt_a];
  end

  assign hazard = out_valid && (out_op == OP_LW) && (out_wadr != '0) && in_valid &&
                  ((use_rs && out_wadr == rs_a) || (use_rt && out_wadr == rt_a));
  assign adv      = out_ready || !out_valid;
  assign in_ready = flush || (adv && !hazard);

  // ID/EX boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_rdata1 <= '0;
      out_rdata2 <= '0;
      out_imm    <= '0;
      out_wadr   <= '0;
      out_we     <= 1'b0;
      hazard_cnt <= '0;
    end else begin
      if (wb_we && wb_adr != '0) rf[wb_adr] <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        if (hazard) begin
          out_valid  <= 1'b0;
          out_op     <= '0;
          out_rdata1 <= '0;
          out_rdata2 <= '0;
          out_imm    <= '0;
          out_wadr   <= '0;
          out_we     <= 1'b0;
          hazard_cnt <= sat_inc(hazard_cnt);
        end else begin
          out_valid  <= in_valid;
          out_op     <= op;
          out_rdata1 <= rs_val;
          out_rdata2 <= rt_val;
          out_imm    <= imm_val;
          out_wadr   <= dst;
          out_we     <= dec_we;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus hazard, hold and flush sequences.
module tb_id_stage_pipe;

  logic        CLK = 1'b0;
  logic        RST, in_valid, in_ready, flush, wb_we, out_valid, out_ready, out_we;
  logic [31:0] Ins, wb_data, out_rdata1, out_rdata2, out_imm;
  logic [4:0]  wb_adr, out_wadr;
  logic [5:0]  out_op;
  logic [15:0] hazard_cnt;

  int checks = 0;
  int errors = 0;

  id_stage_pipe #(.DW(32), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins),
    .flush(flush), .wb_we(wb_we), .wb_adr(wb_adr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm(out_imm),
    .out_wadr(out_wadr), .out_we(out_we), .hazard_cnt(hazard_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic        wbwe;
    logic [4:0]  wbadr;
    logic [31:0] wbdata;
    logic [5:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  wadr;
    logic        we;
  } vec_t;

  vec_t vt[12];

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b1; wb_adr = 5'd5; wb_data = 32'h5555_5555;
    Ins = rtype(5'd5, 5'd5, 5'd3);

    vt[0]  = '{rtype(5'd7, 5'd0, 5'd8), 1'b1, 5'd7, 32'h0000_1234,
               6'h00, 32'h0000_1234, 32'h0, 32'h0000_4021, 5'd8, 1'b1};
    vt[1]  = '{rtype(5'd0, 5'd0, 5'd9), 1'b1, 5'd0, 32'hFFFF_FFFF,
               6'h00, 32'h0, 32'h0, 32'h0000_4821, 5'd9, 1'b1};
    vt[2]  = '{rtype(5'd0, 5'd0, 5'd9), 1'b0, 5'd0, 32'h0,
               6'h00, 32'h0, 32'h0, 32'h0000_4821, 5'd9, 1'b1};
    vt[3]  = '{rtype(5'd7, 5'd5, 5'd0), 1'b0, 5'd0, 32'h0,
               6'h00, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0021, 5'd0, 1'b0};
    vt[4]  = '{itype(6'h0D, 5'd5, 5'd10, 16'h8000), 1'b0, 5'd0, 32'h0,
               6'h0D, 32'hDEAD_BEEF, 32'h0, 32'h0000_8000, 5'd10, 1'b1};
    vt[5]  = '{itype(6'h08, 5'd0, 5'd11, 16'h8000), 1'b0, 5'd0, 32'h0,
               6'h08, 32'h0, 32'h0, 32'hFFFF_8000, 5'd11, 1'b1};
    vt[6]  = '{itype(6'h0F, 5'd0, 5'd12, 16'h8001), 1'b0, 5'd0, 32'h0,
               6'h0F, 32'h0, 32'h0, 32'h8001_0000, 5'd12, 1'b1};
    vt[7]  = '{{6'h03, 26'h000_0010}, 1'b0, 5'd0, 32'h0,
               6'h03, 32'h0, 32'h0, 32'h0000_0010, 5'd31, 1'b1};
    vt[8]  = '{itype(6'h2B, 5'd5, 5'd7, 16'h0004), 1'b0, 5'd0, 32'h0,
               6'h2B, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0004, 5'd7, 1'b0};
    vt[9]  = '{itype(6'h04, 5'd5, 5'd7, 16'hFFFE), 1'b0, 5'd0, 32'h0,
               6'h04, 32'hDEAD_BEEF, 32'h0000_1234, 32'hFFFF_FFFE, 5'd7, 1'b0};
    vt[10] = '{itype(6'h0C, 5'd7, 5'd13, 16'hFFFF), 1'b0, 5'd0, 32'h0,
               6'h0C, 32'h0000_1234, 32'h0, 32'h0000_FFFF, 5'd13, 1'b1};
    vt[11] = '{{6'h02, 26'h3FF_FFFF}, 1'b0, 5'd0, 32'h0,
               6'h02, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd31, 1'b0};

    // Reset with a pending writeback: nothing may land in the array
    tick();
    RST = 1'b0; wb_we = 1'b0; in_valid = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rdata1", out_rdata1, 32'd0);
    chk("rst_wadr", {27'd0, out_wadr}, 32'd0);
    chk("rst_we", {31'd0, out_we}, 32'd0);
    chk("rst_hcnt", {16'd0, hazard_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; Ins = rtype(5'd5, 5'd5, 5'd3);
    tick();
    chk("rst_read_r5", out_rdata1, 32'd0);

    wb_we = 1'b1; wb_adr = 5'd5; wb_data = 32'hDEAD_BEEF; in_valid = 1'b0;
    tick();
    wb_we = 1'b0; in_valid = 1'b1; Ins = rtype(5'd5, 5'd0, 5'd3);
    tick();
    chk("addu_valid", {31'd0, out_valid}, 32'd1);
    chk("addu_rdata1", out_rdata1, 32'hDEAD_BEEF);
    chk("addu_wadr", {27'd0, out_wadr}, 32'd3);
    chk("addu_we", {31'd0, out_we}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      Ins = vt[i].ins; wb_we = vt[i].wbwe; wb_adr = vt[i].wbadr; wb_data = vt[i].wbdata;
      tick();
      wb_we = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_op", i), {26'd0, out_op}, {26'd0, vt[i].op});
      chk($sformatf("v%0d_r1", i), out_rdata1, vt[i].r1);
      chk($sformatf("v%0d_r2", i), out_rdata2, vt[i].r2);
      chk($sformatf("v%0d_imm", i), out_imm, vt[i].imm);
      chk($sformatf("v%0d_wadr", i), {27'd0, out_wadr}, {27'd0, vt[i].wadr});
      chk($sformatf("v%0d_we", i), {31'd0, out_we}, {31'd0, vt[i].we});
    end

    // Load-use: lw r4 then addu reading r4 through rt
    Ins = itype(6'h23, 5'd0, 5'd4, 16'h0000);
    tick();
    chk("lw_op", {26'd0, out_op}, 32'h23);
    Ins = rtype(5'd0, 5'd4, 5'd6);
    #1;
    chk("hz_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("hz_bubble", {31'd0, out_valid}, 32'd0);
    chk("hz_cnt", {16'd0, hazard_cnt}, 32'd1);
    chk("hz_ready_after", {31'd0, in_ready}, 32'd1);
    tick();
    chk("hz_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("hz_issue_wadr", {27'd0, out_wadr}, 32'd6);

    // ori only reads rs, so rt=4 behind a lw must not stall
    Ins = itype(6'h23, 5'd0, 5'd4, 16'h0000);
    tick();
    Ins = itype(6'h0D, 5'd0, 5'd4, 16'h0001);
    #1;
    chk("ori_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("ori_valid", {31'd0, out_valid}, 32'd1);
    chk("ori_op", {26'd0, out_op}, 32'h0D);
    chk("ori_hcnt", {16'd0, hazard_cnt}, 32'd1);

    // EX back-pressure for three cycles
    Ins = rtype(5'd5, 5'd0, 5'd3);
    tick();
    out_ready = 1'b0; Ins = itype(6'h08, 5'd0, 5'd14, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_wadr", i), {27'd0, out_wadr}, 32'd3);
      chk($sformatf("hold%0d_r1", i), out_rdata1, 32'hDEAD_BEEF);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("release_op", {26'd0, out_op}, 32'h08);
    chk("release_wadr", {27'd0, out_wadr}, 32'd14);

    // Flush overrides a pending load-use hazard
    Ins = itype(6'h23, 5'd0, 5'd4, 16'h0000);
    tick();
    Ins = rtype(5'd0, 5'd4, 5'd6); flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_hcnt", {16'd0, hazard_cnt}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
